// File: rtl/jac2_pkg.sv
// rtl/jac2_pkg.sv - control-field opcodes and sequencer state encodings
package jac2_pkg;

  localparam logic [2:0] CTL_SEQ  = 3'd0;
  localparam logic [2:0] CTL_JMP  = 3'd1;
  localparam logic [2:0] CTL_BRT  = 3'd2;
  localparam logic [2:0] CTL_BRF  = 3'd3;
  localparam logic [2:0] CTL_CALL = 3'd4;
  localparam logic [2:0] CTL_RET  = 3'd5;
  localparam logic [2:0] CTL_HALT = 3'd6;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_EXEC   = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

endpackage

// File: rtl/jac2_sequencer_if.sv
// rtl/jac2_sequencer_if.sv - instruction fetch and decoder handshake bundle
interface jac2_sequencer_if #(
  parameter int PC_WIDTH        = 8,
  parameter int IR_WIDTH        = 16,
  parameter int NUM_STATUS_BITS = 3
);

  logic                       imem_req;
  logic [PC_WIDTH-1:0]        imem_addr;
  logic                       imem_ack;
  logic [IR_WIDTH-1:0]        imem_data;
  logic [IR_WIDTH-1:0]        ir;
  logic                       ir_valid;
  logic                       stall;
  logic [NUM_STATUS_BITS-1:0] status;

  modport master (
    output imem_req, imem_addr, ir, ir_valid,
    input  imem_ack, imem_data, stall, status
  );

  modport slave (
    input  imem_req, imem_addr, ir, ir_valid,
    output imem_ack, imem_data, stall, status
  );

endinterface

// File: rtl/jac2_ret_stack.sv
// rtl/jac2_ret_stack.sv - LIFO of return addresses for CALL/RET
module jac2_ret_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);

  localparam int SPW = $clog2(DEPTH + 1);

  logic [SPW-1:0]   sp_q, sp_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign full  = (sp_q == SPW'(DEPTH));
  assign empty = (sp_q == '0);

  always_comb begin
    sp_d = sp_q;
    if (push && !full) begin
      sp_d = sp_q + SPW'(1);
    end else if (pop && !empty) begin
      sp_d = sp_q - SPW'(1);
    end
  end

  // sp points one past the newest entry
  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sp_q == SPW'(i + 1)) top = mem_q[i];
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      sp_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sp_q <= sp_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (push && !full && sp_q == SPW'(i)) mem_q[i] <= push_data;
      end
    end
  end

endmodule

// File: rtl/jac2_sequencer.sv
// rtl/jac2_sequencer.sv - fetch/execute sequencer with branches and a return stack
module jac2_sequencer
  import jac2_pkg::*;
#(
  parameter int PC_WIDTH        = 8,
  parameter int IR_WIDTH        = 16,
  parameter int STACK_DEPTH     = 4,
  parameter int NUM_STATUS_BITS = 3
) (
  input  logic                clk,
  input  logic                res,
  jac2_sequencer_if.master    bus,
  output logic [PC_WIDTH-1:0] pc,
  output logic                halted,
  output logic                fault
);

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic                fault_q, fault_d;

  logic                stk_push, stk_pop, stk_full, stk_empty;
  logic [PC_WIDTH-1:0] stk_top;

  logic [2:0]          ctl;
  logic [1:0]          flag_idx;
  logic                flag;
  logic [PC_WIDTH-1:0] target;
  logic [PC_WIDTH-1:0] link;

  assign ctl      = ir_q[IR_WIDTH-1 -: 3];
  assign flag_idx = ir_q[IR_WIDTH-4 -: 2];
  assign target   = ir_q[PC_WIDTH-1:0];
  assign link     = pc_q + PC_WIDTH'(1);

  // indices beyond the implemented flags read as 0
  always_comb begin
    flag = 1'b0;
    for (int i = 0; i < NUM_STATUS_BITS && i < 4; i++) begin
      if (int'(flag_idx) == i) flag = bus.status[i];
    end
  end

  jac2_ret_stack #(
    .WIDTH (PC_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk       (clk),
    .res       (res),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (link),
    .top       (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    fault_d  = fault_q;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (bus.imem_ack) begin
          ir_d    = bus.imem_data;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (!bus.stall) begin
          state_d = ST_FETCH;
          case (ctl)
            CTL_JMP: pc_d = target;
            CTL_BRT: pc_d = flag ? target : link;
            CTL_BRF: pc_d = flag ? link : target;
            CTL_CALL: begin
              if (stk_full) begin
                fault_d = 1'b1;
                state_d = ST_HALTED;
              end else begin
                stk_push = 1'b1;
                pc_d     = target;
              end
            end
            CTL_RET: begin
              if (stk_empty) begin
                fault_d = 1'b1;
                state_d = ST_HALTED;
              end else begin
                stk_pop = 1'b1;
                pc_d    = stk_top;
              end
            end
            CTL_HALT: state_d = ST_HALTED;
            default:  pc_d = link;
          endcase
        end
      end
      default: state_d = ST_HALTED;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      fault_q <= fault_d;
    end
  end

  // reset already parks the FSM in FETCH, so the request is masked until res drops
  assign bus.imem_req  = (state_q == ST_FETCH) && !res;
  assign bus.imem_addr = pc_q;
  assign bus.ir        = ir_q;
  assign bus.ir_valid  = (state_q == ST_EXEC);
  assign pc            = pc_q;
  assign halted        = (state_q == ST_HALTED);
  assign fault         = fault_q;

endmodule

// File: tb/tb_jac2_sequencer.sv
// tb/tb_jac2_sequencer.sv - directed trace-table bench for jac2_sequencer
module tb_jac2_sequencer;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic [7:0] pc;
  logic       halted;
  logic       fault;
  int         n_checks = 0;
  int         n_fail   = 0;

  jac2_sequencer_if #(.PC_WIDTH(8), .IR_WIDTH(16), .NUM_STATUS_BITS(3)) bus ();

  jac2_sequencer #(
    .PC_WIDTH(8), .IR_WIDTH(16), .STACK_DEPTH(4), .NUM_STATUS_BITS(3)
  ) dut (
    .clk    (clk),
    .res    (res),
    .bus    (bus),
    .pc     (pc),
    .halted (halted),
    .fault  (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_first;
    logic [15:0] instr;
    logic [2:0]  st;
    int          ack_dly;
    int          stall_n;
    logic [7:0]  pc;
    logic [7:0]  nxt;
    logic        halt;
    logic        flt;
  } vec_t;

  vec_t tv[$];

  function automatic logic [15:0] ins(input logic [2:0] c, input logic [1:0] f, input logic [7:0] t);
    return {c, f, 3'b000, t};
  endfunction

  function automatic vec_t mkv(input logic r, input logic [15:0] i, input logic [2:0] s, input int ad,
                               input int sn, input logic [7:0] p, input logic [7:0] n,
                               input logic h, input logic f);
    vec_t v;
    v.rst_first = r; v.instr = i; v.st = s; v.ack_dly = ad; v.stall_n = sn;
    v.pc = p; v.nxt = n; v.halt = h; v.flt = f;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    #2;
    res = 1'b1;
    #1;
    chk("rst_req",    32'(bus.imem_req), 32'(0));
    chk("rst_valid",  32'(bus.ir_valid), 32'(0));
    chk("rst_halted", 32'(halted),       32'(0));
    chk("rst_fault",  32'(fault),        32'(0));
    chk("rst_pc",     32'(pc),           32'(0));
    chk("rst_ir",     32'(bus.ir),       32'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    res = 1'b0;
    #1;
    chk("post_rst_req",  32'(bus.imem_req),  32'(1));
    chk("post_rst_addr", 32'(bus.imem_addr), 32'(0));
  endtask

  // one full fetch + execute; returns just after the retiring edge
  task automatic do_instr(input string nm, input logic [15:0] instr, input logic [2:0] st,
                          input int ack_dly, input int stall_n, input logic [7:0] exp_pc);
    chk({nm, "_fetch_addr"}, 32'(bus.imem_addr), 32'(exp_pc));
    chk({nm, "_fetch_req"},  32'(bus.imem_req),  32'(1));
    for (int k = 0; k < ack_dly; k++) begin
      bus.imem_ack = 1'b0;
      step();
      chk({nm, "_wait_addr"},  32'(bus.imem_addr), 32'(exp_pc));
      chk({nm, "_wait_valid"}, 32'(bus.ir_valid),  32'(0));
    end
    bus.imem_ack  = 1'b1;
    bus.imem_data = instr;
    step();
    chk({nm, "_exec_valid"}, 32'(bus.ir_valid), 32'(1));
    chk({nm, "_exec_ir"},    32'(bus.ir),       32'(instr));
    chk({nm, "_exec_req"},   32'(bus.imem_req), 32'(0));
    for (int k = 0; k < stall_n; k++) begin
      bus.stall     = 1'b1;
      bus.status    = ~st;
      bus.imem_ack  = 1'b1;
      bus.imem_data = 16'hFFFF;
      step();
      chk({nm, "_stall_valid"}, 32'(bus.ir_valid), 32'(1));
      chk({nm, "_stall_ir"},    32'(bus.ir),       32'(instr));
      chk({nm, "_stall_pc"},    32'(pc),           32'(exp_pc));
    end
    bus.imem_ack  = 1'b0;
    bus.imem_data = 16'h0000;
    bus.stall     = 1'b0;
    bus.status    = st;
    step();
    bus.status = 3'b000;
  endtask

  initial begin
    bus.imem_ack  = 1'b0;
    bus.imem_data = 16'h0000;
    bus.stall     = 1'b0;
    bus.status    = 3'b000;

    // main trace from reset
    tv.push_back(mkv(1, ins(3'd0, 2'd0, 8'h00), 3'b000, 0, 0, 8'h00, 8'h01, 0, 0));
    tv.push_back(mkv(0, ins(3'd0, 2'd0, 8'h00), 3'b000, 0, 0, 8'h01, 8'h02, 0, 0));
    tv.push_back(mkv(0, ins(3'd0, 2'd0, 8'h00), 3'b000, 0, 0, 8'h02, 8'h03, 0, 0));
    tv.push_back(mkv(0, ins(3'd1, 2'd0, 8'h10), 3'b000, 0, 0, 8'h03, 8'h10, 0, 0));
    tv.push_back(mkv(0, ins(3'd0, 2'd0, 8'h00), 3'b000, 3, 2, 8'h10, 8'h11, 0, 0));
    tv.push_back(mkv(0, ins(3'd2, 2'd1, 8'h40), 3'b010, 0, 0, 8'h11, 8'h40, 0, 0));
    tv.push_back(mkv(0, ins(3'd2, 2'd1, 8'h50), 3'b000, 0, 1, 8'h40, 8'h41, 0, 0));
    tv.push_back(mkv(0, ins(3'd3, 2'd3, 8'h05), 3'b111, 0, 0, 8'h41, 8'h05, 0, 0));
    tv.push_back(mkv(0, ins(3'd4, 2'd0, 8'h20), 3'b000, 1, 0, 8'h05, 8'h20, 0, 0));
    tv.push_back(mkv(0, ins(3'd5, 2'd0, 8'h00), 3'b000, 0, 1, 8'h20, 8'h06, 0, 0));
    tv.push_back(mkv(0, ins(3'd3, 2'd0, 8'h99), 3'b001, 0, 0, 8'h06, 8'h07, 0, 0));
    tv.push_back(mkv(0, ins(3'd7, 2'd0, 8'h33), 3'b000, 0, 0, 8'h07, 8'h08, 0, 0));
    tv.push_back(mkv(0, ins(3'd1, 2'd0, 8'hFF), 3'b000, 0, 0, 8'h08, 8'hFF, 0, 0));
    tv.push_back(mkv(0, ins(3'd0, 2'd0, 8'h00), 3'b000, 0, 0, 8'hFF, 8'h00, 0, 0));
    tv.push_back(mkv(0, ins(3'd6, 2'd0, 8'h00), 3'b000, 0, 0, 8'h00, 8'h00, 1, 0));
    // four nested calls fit, the fifth overflows
    tv.push_back(mkv(1, ins(3'd4, 2'd0, 8'h10), 3'b000, 0, 0, 8'h00, 8'h10, 0, 0));
    tv.push_back(mkv(0, ins(3'd4, 2'd0, 8'h20), 3'b000, 0, 0, 8'h10, 8'h20, 0, 0));
    tv.push_back(mkv(0, ins(3'd4, 2'd0, 8'h30), 3'b000, 0, 0, 8'h20, 8'h30, 0, 0));
    tv.push_back(mkv(0, ins(3'd4, 2'd0, 8'h40), 3'b000, 0, 0, 8'h30, 8'h40, 0, 0));
    tv.push_back(mkv(0, ins(3'd4, 2'd0, 8'h50), 3'b000, 0, 0, 8'h40, 8'h40, 1, 1));
    // underflow
    tv.push_back(mkv(1, ins(3'd5, 2'd0, 8'h00), 3'b000, 0, 0, 8'h00, 8'h00, 1, 1));
    // two-deep call/return unwinds in LIFO order
    tv.push_back(mkv(1, ins(3'd4, 2'd0, 8'h60), 3'b000, 0, 0, 8'h00, 8'h60, 0, 0));
    tv.push_back(mkv(0, ins(3'd4, 2'd0, 8'h70), 3'b000, 0, 0, 8'h60, 8'h70, 0, 0));
    tv.push_back(mkv(0, ins(3'd5, 2'd0, 8'h00), 3'b000, 0, 0, 8'h70, 8'h61, 0, 0));
    tv.push_back(mkv(0, ins(3'd5, 2'd0, 8'h00), 3'b000, 0, 0, 8'h61, 8'h01, 0, 0));

    foreach (tv[i]) begin
      string nm;
      nm = $sformatf("v%0d", i);
      if (tv[i].rst_first) apply_reset();
      do_instr(nm, tv[i].instr, tv[i].st, tv[i].ack_dly, tv[i].stall_n, tv[i].pc);
      if (tv[i].halt) begin
        chk({nm, "_halted"}, 32'(halted),       32'(1));
        chk({nm, "_fault"},  32'(fault),        32'(tv[i].flt));
        chk({nm, "_req"},    32'(bus.imem_req), 32'(0));
        chk({nm, "_valid"},  32'(bus.ir_valid), 32'(0));
        bus.imem_ack = 1'b1;
        step();
        step();
        bus.imem_ack = 1'b0;
        chk({nm, "_stay_halted"}, 32'(halted),       32'(1));
        chk({nm, "_stay_req"},    32'(bus.imem_req), 32'(0));
      end else begin
        chk({nm, "_next_addr"}, 32'(bus.imem_addr), 32'(tv[i].nxt));
        chk({nm, "_next_pc"},   32'(pc),            32'(tv[i].nxt));
        chk({nm, "_next_req"},  32'(bus.imem_req),  32'(1));
        chk({nm, "_halted"},    32'(halted),        32'(0));
        chk({nm, "_fault"},     32'(fault),         32'(0));
      end
    end

    // reset during a stalled EXEC at 0x33 after a CALL has pushed
    apply_reset();
    do_instr("ms_call", ins(3'd4, 2'd0, 8'h33), 3'b000, 0, 0, 8'h00);
    chk("ms_addr", 32'(bus.imem_addr), 32'(8'h33));
    bus.imem_ack  = 1'b1;
    bus.imem_data = ins(3'd0, 2'd0, 8'h00);
    step();
    bus.imem_ack = 1'b0;
    bus.stall    = 1'b1;
    step();
    step();
    chk("ms_stall_valid", 32'(bus.ir_valid), 32'(1));
    chk("ms_stall_pc",    32'(pc),           32'(8'h33));
    apply_reset();
    bus.stall = 1'b0;
    do_instr("ms_ret", ins(3'd5, 2'd0, 8'h00), 3'b000, 0, 0, 8'h00);
    chk("ms_stack_cleared_fault",  32'(fault),  32'(1));
    chk("ms_stack_cleared_halted", 32'(halted), 32'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jac2_sequencer.md
# jac2_sequencer

Parametrised instruction sequencer for the second-generation JAC core. It replaces the free-running program counter with a fetch/execute state machine. The machine fetches over a req/ack handshake from instruction memory and presents each instruction to the decoder with a stall-able valid. It resolves jumps, status-conditional branches, and CALL/RET through a hardware return stack, and signals HALT and stack faults. It sits between instruction memory and the decoder/ALU datapath.

## Interface
- PC_WIDTH, 8, program counter and instruction address width
- IR_WIDTH, 16, instruction width; must be ≥ PC_WIDTH+5
- STACK_DEPTH, 4, return stack entries (≥1)
- NUM_STATUS_BITS, 3, ALU status flags
- clk  in  1  system clock, all state on rising edge
- res  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request
- imem_addr  out  PC_WIDTH  fetch address (= pc)
- imem_ack  in  1  fetch complete, imem_data valid this cycle
- imem_data  in  IR_WIDTH  fetched instruction
- ir  out  IR_WIDTH  latched current instruction
- ir_valid  out  1  ir is being executed by the datapath
- stall  in  1  datapath not ready to retire ir
- status  in  NUM_STATUS_BITS  ALU flags, sampled at retire
- pc  out  PC_WIDTH  address of current instruction
- halted  out  1  sequencer stopped
- fault  out  1  sticky: stack overflow/underflow

## Operation
- Control field ctl = ir[IR_WIDTH-1:IR_WIDTH-3]:
  - 0 SEQ
  - 1 JMP
  - 2 BRT (jump if flag set)
  - 3 BRF (jump if flag clear)
  - 4 CALL
  - 5 RET
  - 6 HALT
  - 7 treated as SEQ
- Flag index = ir[IR_WIDTH-4:IR_WIDTH-5]. An index ≥ NUM_STATUS_BITS reads as 0, so BRT falls through and BRF jumps.
- Target = ir[PC_WIDTH-1:0]. Link value = pc+1.
- All pc arithmetic is mod 2^PC_WIDTH: pc 0xFF +1 → 0x00 at width 8.
- States:
  - FETCH: imem_req=1, imem_addr=pc held stable. On imem_ack: ir←imem_data, go EXEC.
  - EXEC: ir_valid=1. With stall=1, stay, and hold ir/pc. With stall=0, retire: compute next pc, update the stack, go FETCH; HALT goes to HALTED.
  - HALTED: halted=1, imem_req=0, ir_valid=0. Only reset exits.
- Next pc on retire:
  - SEQ/7: pc+1.
  - JMP: target.
  - BRT/BRF: target if the condition holds, else pc+1.
  - CALL: push pc+1, pc←target.
  - RET: pop into pc.
- CALL with the stack full: no push, fault←1, go HALTED. RET with the stack empty: same.
- imem_ack is ignored outside FETCH.

## Timing
- Reset (asynchronous, immediate): pc=0, ir=0, state=FETCH, stack pointer=0.
- Output values during reset: imem_req=0, ir_valid=0, halted=0, fault=0.
- imem_req rises in the first cycle after res falls.
- Minimum 2 cycles per instruction: 1 FETCH cycle with ack in the same cycle, plus 1 EXEC cycle.
- Each cycle of ack delay or stall adds exactly 1 cycle.
- status is sampled only on the retiring EXEC edge (stall=0).
- The new pc is visible on imem_addr in the cycle after retire.
- Reset asserted mid-fetch or mid-stall abandons the instruction. No stack or fault state survives.
- Depth boundary: STACK_DEPTH nested CALLs succeed. Call number STACK_DEPTH+1 faults.

## Structure
- Package jac2_pkg holds:
  - ctl opcode localparams (CTL_SEQ … CTL_HALT)
  - state encodings (ST_FETCH, ST_EXEC, ST_HALTED)
- Sub-module jac2_ret_stack holds the LIFO and exposes:
  - inputs: push, pop, push data
  - outputs: top, full, empty
  - parameters: width PC_WIDTH, depth STACK_DEPTH
  - asynchronous res

## Test plan
- Straight-line SEQ from reset, ack same cycle → pc 0,1,2,3 on successive FETCH cycles; ir_valid every other cycle.
- Fetch at pc=0x10, ack delayed 3 cycles and stall held 2 cycles → imem_addr holds 0x10 throughout; one retire; next fetch at 0x11.
- BRT flag 1 target 0x40: status=3'b010 → next pc 0x40. Same with status=3'b000 → next pc pc+1. BRF with flag index 3 → jumps.
- CALL 0x20 from 0x05, then RET → pc 0x20, then 0x06. Nest 4 CALLs with STACK_DEPTH=4 → OK; a 5th CALL → fault=1, halted=1, imem_req=0.
- RET on empty stack → fault=1, halted=1. JMP at pc 0xFF with SEQ → pc wraps to 0x00.
- Assert res during a stalled EXEC at pc 0x33 → pc=0, fault=0, halted=0, ir_valid=0 immediately; fetch restarts at 0x00.
